// File: rtl/npu_pkg.sv
// npu_pkg: shared FSM state type, FP16 field constants and default widths for the
// NPU datapath blocks.
package npu_pkg;

    // Default buffer / element / dimension widths.
    localparam int unsigned DEF_ADDR_W = 14;
    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_DIM_W  = 10;

    // IEEE-754 binary16 constants.
    localparam logic [4:0]  EXP_MAX  = 5'h1F;
    localparam logic [15:0] POS_ZERO = 16'h0000;
    localparam logic [15:0] NEG_ZERO = 16'h8000;

    // Activation pass sequencer states.
    typedef enum logic [1:0] {
        StIdle,
        StPrime,
        StRun,
        StFinish
    } act_state_t;

endpackage

// File: rtl/fp16_relu.sv
// fp16_relu: combinational FP16 ReLU. With LEAKY_RELU_EN defined, negative finite
// inputs are scaled by 2^-k (exponent decrement) instead of being flushed to zero.
module fp16_relu
    import npu_pkg::*;
(
    input  logic [15:0] x,
`ifdef LEAKY_RELU_EN
    input  logic [3:0]  k,
`endif
    output logic [15:0] y
);

    logic       sign;
    logic [4:0] expo;
    logic [9:0] mant;

    assign sign = x[15];
    assign expo = x[14:10];
    assign mant = x[9:0];

    // Classify the input and select the activated value.
    always_comb begin
        y = x;
        if (expo == EXP_MAX && mant != 10'd0) begin
            // NaN of either sign passes unchanged.
            y = x;
        end else if (!sign) begin
            // Positive: subnormals (and +0) flush to +0, everything else passes.
            y = (expo == 5'd0) ? POS_ZERO : x;
        end else begin
`ifdef LEAKY_RELU_EN
            if (k == 4'd0) begin
                y = POS_ZERO;
            end else if (expo == EXP_MAX) begin
                y = x;
            end else if (expo <= {1'b0, k}) begin
                // Scaled value would underflow the normal range.
                y = NEG_ZERO;
            end else begin
                y = {1'b1, expo - {1'b0, k}, mant};
            end
`else
            y = POS_ZERO;
`endif
        end
    end

endmodule

// File: rtl/matrix_activation.sv
// matrix_activation: streams row_size*col_size FP16 elements from a source buffer
// through fp16_relu into a destination buffer at one element per cycle.
// Optional macro LEAKY_RELU_EN adds the leak_shift input (leaky ReLU slope 2^-k).
module matrix_activation
    import npu_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DIM_W  = DEF_DIM_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              done,
    input  logic [ADDR_W-1:0] src_start_address,
    output logic [ADDR_W-1:0] src_address,
    input  logic [DATA_W-1:0] src_readdata,
    input  logic [DIM_W-1:0]  row_size,
    input  logic [DIM_W-1:0]  col_size,
    input  logic [ADDR_W-1:0] dest_start_address,
    output logic [ADDR_W-1:0] dest_address,
    output logic [DATA_W-1:0] dest_writedata,
    output logic              dest_write_en
`ifdef LEAKY_RELU_EN
    ,
    input  logic [3:0]        leak_shift
`endif
);

    localparam logic [ADDR_W-1:0]  ADDR_ONE = ADDR_W'(1);
    localparam logic [2*DIM_W-1:0] CNT_ONE  = (2 * DIM_W)'(1);

    act_state_t         state_q;
    logic [ADDR_W-1:0]  dest_base_q;
    logic [2*DIM_W-1:0] total_q;
    logic [2*DIM_W-1:0] idx_q;      // index of the next element to be written
    logic [2*DIM_W-1:0] row_ext;
    logic [2*DIM_W-1:0] col_ext;
    logic [2*DIM_W-1:0] total_in;
    logic [DATA_W-1:0]  act;

    assign row_ext  = {{DIM_W{1'b0}}, row_size};
    assign col_ext  = {{DIM_W{1'b0}}, col_size};
    assign total_in = row_ext * col_ext;

    fp16_relu u_relu (
        .x (src_readdata),
`ifdef LEAKY_RELU_EN
        .k (leak_shift),
`endif
        .y (act)
    );

    // Pass sequencer; every output is registered. Read address runs two elements
    // ahead of the write being presented, so in-place passes never read stale data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            done           <= 1'b1;
            dest_write_en  <= 1'b0;
            src_address    <= src_start_address;
            dest_address   <= dest_start_address;
            dest_writedata <= '0;
            dest_base_q    <= '0;
            total_q        <= '0;
            idx_q          <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    dest_write_en <= 1'b0;
                    dest_address  <= dest_start_address;
                    if (start) begin
                        dest_base_q <= dest_start_address;
                        total_q     <= total_in;
                        idx_q       <= '0;
                        done        <= 1'b0;
                        src_address <= src_start_address + ADDR_ONE;
                        state_q     <= (total_in == '0) ? StFinish : StPrime;
                    end else begin
                        done        <= 1'b1;
                        src_address <= src_start_address;
                    end
                end
                StPrime: begin
                    // Data for element 0 is on src_readdata now.
                    src_address    <= src_address + ADDR_ONE;
                    dest_write_en  <= 1'b1;
                    dest_address   <= dest_base_q;
                    dest_writedata <= act;
                    idx_q          <= CNT_ONE;
                    state_q        <= StRun;
                end
                StRun: begin
                    src_address <= src_address + ADDR_ONE;
                    if (idx_q == total_q) begin
                        dest_write_en <= 1'b0;
                        done          <= 1'b1;
                        state_q       <= StFinish;
                    end else begin
                        dest_write_en  <= 1'b1;
                        dest_address   <= dest_address + ADDR_ONE;
                        dest_writedata <= act;
                        idx_q          <= idx_q + CNT_ONE;
                    end
                end
                StFinish: begin
                    // done is raised by the last RUN cycle, or by IDLE on the
                    // zero-size path.
                    dest_write_en <= 1'b0;
                    src_address   <= src_start_address;
                    state_q       <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/matrix_activation.md
MATRIX_ACTIVATION -- requirements
Module: matrix_activation

Interface
REQ-001 Parameter ADDR_W, default 14, word-address width of source and destination buffers.
REQ-002 Parameter DATA_W, default 16, element width; the element format is IEEE-754 binary16.
REQ-003 Parameter DIM_W, default 10, width of the row and column size inputs.
REQ-004 clk  input  1  clock; all logic is on the rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  launch request; sampled only in IDLE.
REQ-007 done  output  1  high when idle or finished; low while a pass is in progress.
REQ-008 src_start_address  input  ADDR_W  base address of the input matrix (the subtraction-stage result buffer).
REQ-009 src_address  output  ADDR_W  read address; read data returns exactly 1 cycle later.
REQ-010 src_readdata  input  DATA_W  read data for the address presented in the previous cycle.
REQ-011 row_size, col_size  input  DIM_W each  matrix dimensions; element count is row_size*col_size.
REQ-012 dest_start_address  input  ADDR_W  base address of the output matrix; it may equal src_start_address (in-place).
REQ-013 dest_address  output  ADDR_W  write address.
REQ-014 dest_writedata  output  DATA_W  activated element.
REQ-015 dest_write_en  output  1  one-cycle write strobe per element.
REQ-016 leak_shift  input  4  leaky slope exponent k (slope 2^-k); present only when LEAKY_RELU_EN is defined.

Function
REQ-017 FSM states: IDLE, PRIME, RUN, FINISH; the encoding comes from the package.
REQ-018 IDLE: done=1, dest_write_en=0, src_address=src_start_address. When start=1, latch sizes and bases, set total=row_size*col_size (2*DIM_W bits), drive done=0 on the next cycle and go to PRIME.
REQ-019 Zero size: if total==0, go to FINISH directly; no write is issued.
REQ-020 PRIME (1 cycle): src_address=base+1; no write.
REQ-021 RUN: each cycle assert dest_write_en=1 with dest_address=dest_base+i and dest_writedata=f(src_readdata); advance i and src_address by 1; throughput is 1 element per cycle.
REQ-022 Latency: the first write strobe occurs 2 cycles after start is sampled; the last write occurs at cycle total+1.
REQ-023 After writing element total-1, go to FINISH; FINISH drives dest_write_en=0, done=1 and returns to IDLE.
REQ-024 In-place operation is safe because read index i+1 always precedes write index i.
REQ-025 start asserted outside IDLE is ignored; size and base changes mid-pass are ignored because values are latched.
REQ-026 Address arithmetic wraps modulo 2^ADDR_W without error.
REQ-027 ReLU f(x): sign=0 passes x unchanged, including +inf; NaN (exp=31, mant!=0) passes unchanged; negative values including -0 and -inf give 16'h0000; subnormal inputs (exp=0) give 16'h0000.

Reset
REQ-028 reset wins over all other inputs: state=IDLE, done=1, dest_write_en=0, src_address=src_start_address, dest_address=dest_start_address, dest_writedata=0, counters=0.
REQ-029 reset mid-pass aborts immediately; no further write strobe occurs from the cycle after reset is sampled.

Configuration
REQ-030 Macro LEAKY_RELU_EN.
- Defined: negative finite x gives x*2^-k by subtracting k from the exponent, sign kept.
- Defined: if exp<=k the result is 16'h8000.
- Defined: k=0 gives 16'h0000 (plain ReLU); -inf gives -inf.
- Undefined: the leak_shift port is absent and REQ-027 applies.

Structure
REQ-031 Package npu_pkg holds the FSM state typedef, FP16 field constants (EXP_MAX=5'h1F, POS_ZERO=16'h0000, NEG_ZERO=16'h8000) and the ADDR_W, DATA_W and DIM_W defaults.
REQ-032 Combinational sub-module fp16_relu maps (x, k) to f(x); all sequencing lives in matrix_activation.

Verification
REQ-033 2x3 matrix of {0x3C00, 0xBC00, 0x4000, 0x8000, 0x7E00, 0xFC00}, macro undefined -> writes {0x3C00, 0x0000, 0x4000, 0x0000, 0x7E00, 0x0000} on 6 consecutive cycles, first write 2 cycles after start, done high 1 cycle after the last write.
REQ-034 LEAKY_RELU_EN, k=2, inputs {0xC400, 0x8400, 0xFC00} -> outputs {0xBC00, 0x8000, 0xFC00}.
REQ-035 row_size=0, col_size=5 -> no dest_write_en pulse; done low for exactly 2 cycles.
REQ-036 In-place 10x10 matrix with src base = dest base = 0x3FFA -> 100 writes wrapping through 0x0000, every result correct.
REQ-037 reset asserted on the 4th RUN cycle of a 4x4 pass, then start re-pulsed -> write stops after the reset cycle, then a full 16-element pass completes correctly.
REQ-038 start held high for the whole of a 3x3 pass -> exactly one pass of 9 writes, followed by a new pass only after return to IDLE.
